// File: rtl/jk_reg_arbiter_pkg.sv
// Shared definitions for the round-robin JK register arbiter: opcodes,
// control FSM states and the command counter width.
package jk_reg_arbiter_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_TOG  = 2'b11;

  localparam int CNT_W = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/jk_reg_arbiter_cell.sv
// Single JK flip-flop bit: hold on 00, clear on 01, set on 10, toggle on 11.
// Synchronous active-high reset clears the bit.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case ({j, k})
      2'b00:   q_d = q_q;
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      default: q_d = ~q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: rtl/jk_reg_arbiter.sv
// Round-robin arbiter granting one requester per cycle access to a shared
// WIDTH-bit register built from JK cells.
module jk_reg_arbiter
  import jk_reg_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_data,
  input  logic [WIDTH*NREQ-1:0] req_mask,
  output logic [NREQ-1:0]       req_ready,
  output logic [2:0]            grant_id,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qb,
  output logic                  upd,
  output logic [CNT_W-1:0]      cmd_cnt
);

  // Handshake: a command transfers in any cycle where req_valid[i] and
  // req_ready[i] are both high; the requester keeps op/data/mask stable until
  // then, and dropping valid beforehand withdraws the command.

  state_e             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]    ready;
  logic [2:0]         gid;
  logic               xfer;
  logic [1:0]         g_op;
  logic [WIDTH-1:0]   g_data, g_mask;
  logic [WIDTH-1:0]   j, k;

  // Search upward from ptr, wrapping at NREQ; first valid requester wins.
  always_comb begin
    int  idx;
    logic found;
    ready = '0;
    gid   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        ready[idx] = 1'b1;
        gid        = 3'(idx);
      end
    end
    if (rst) begin
      ready = '0;
      gid   = '0;
    end
  end

  assign xfer = |(req_valid & ready);

  always_comb begin
    g_op   = req_op[2*int'(gid) +: 2];
    g_data = req_data[WIDTH*int'(gid) +: WIDTH];
    g_mask = req_mask[WIDTH*int'(gid) +: WIDTH];
    j      = '0;
    k      = '0;
    if (xfer) begin
      case (g_op)
        OP_LOAD: begin j = g_mask & g_data; k = g_mask & ~g_data; end
        OP_SET:  begin j = g_mask;          k = '0;               end
        OP_CLR:  begin j = '0;              k = g_mask;           end
        default: begin j = g_mask;          k = g_mask;           end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    if (xfer)  state_d = ACTIVE;
      default: if (!xfer) state_d = IDLE;
    endcase
    if (xfer) begin
      ptr_d = (int'(gid) == NREQ - 1) ? 3'd0 : gid + 3'd1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j[b]),
      .k   (k[b]),
      .q   (q[b]),
      .qb  (qb[b])
    );
  end

  assign req_ready = ready;
  assign grant_id  = gid;
  assign upd       = (state_q == ACTIVE);
  assign cmd_cnt   = cnt_q;

endmodule

// File: tb/tb_jk_reg_arbiter.sv
// Directed bench for jk_reg_arbiter: reset, opcodes, round-robin order,
// withdrawal, counter wrap and mid-stream reset.
module tb_jk_reg_arbiter;
  import jk_reg_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [7:0]  req_op = '0;
  logic [31:0] req_data = '0;
  logic [31:0] req_mask = '0;
  logic [3:0]  req_ready;
  logic [2:0]  grant_id;
  logic [7:0]  q, qb;
  logic        upd;
  logic [15:0] cmd_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  jk_reg_arbiter #(.WIDTH(8), .NREQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_data(req_data), .req_mask(req_mask), .req_ready(req_ready),
    .grant_id(grant_id), .q(q), .qb(qb), .upd(upd), .cmd_cnt(cmd_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks run on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_op    = '0;
    req_data  = '0;
    req_mask  = '0;
  endtask

  task automatic drive_req(input int i, input logic [1:0] op,
                           input logic [7:0] d, input logic [7:0] m);
    req_valid[i]      = 1'b1;
    req_op[2*i +: 2]  = op;
    req_data[8*i +: 8] = d;
    req_mask[8*i +: 8] = m;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    clear_reqs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b1;
    clear_reqs();
    drive_req(1, OP_SET, 8'h00, 8'h00);
    drive_req(3, OP_TOG, 8'hFF, 8'hFF);
    @(negedge clk);
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    tests_run++; if (grant_id !== 3'd0) begin tests_failed++; $display("FAIL rst_gid: got %0d want 0", grant_id); end
    tick();
    @(negedge clk);
    tests_run++; if (q !== 8'h00) begin tests_failed++; $display("FAIL rst_q: got %h want 00", q); end
    tests_run++; if (qb !== 8'hFF) begin tests_failed++; $display("FAIL rst_qb: got %h want ff", qb); end
    tests_run++; if (upd !== 1'b0) begin tests_failed++; $display("FAIL rst_upd: got %b want 0", upd); end
    tests_run++; if (cmd_cnt !== 16'h0000) begin tests_failed++; $display("FAIL rst_cnt: got %h want 0000", cmd_cnt); end
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL rst_ready_hold: got %b want 0000", req_ready); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL post_rst_ready: got %b want 0010", req_ready); end
    tests_run++; if (grant_id !== 3'd1) begin tests_failed++; $display("FAIL post_rst_gid: got %0d want 1", grant_id); end
    tick();
    req_valid = '0;
    @(negedge clk);
    tests_run++; if (q !== 8'h00) begin tests_failed++; $display("FAIL zero_mask_q: got %h want 00", q); end
    tests_run++; if (upd !== 1'b1) begin tests_failed++; $display("FAIL zero_mask_upd: got %b want 1", upd); end
    tests_run++; if (cmd_cnt !== 16'h0001) begin tests_failed++; $display("FAIL zero_mask_cnt: got %h want 0001", cmd_cnt); end
    tick();
    req_valid = 4'b1111;
    @(negedge clk);
    tests_run++; if (upd !== 1'b0) begin tests_failed++; $display("FAIL idle_upd: got %b want 0", upd); end
    tests_run++; if (grant_id !== 3'd2) begin tests_failed++; $display("FAIL zero_mask_ptr: got %0d want 2", grant_id); end
    tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL zero_mask_ready: got %b want 0100", req_ready); end
    tick();
    clear_reqs();
  endtask

  task automatic test_load_ops();
    do_reset();
    drive_req(0, OP_LOAD, 8'hA5, 8'hFF);
    @(negedge clk);
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL load_ready: got %b want 0001", req_ready); end
    tick();
    drive_req(0, OP_SET, 8'h00, 8'h0F);
    @(negedge clk);
    tests_run++; if (q !== 8'hA5) begin tests_failed++; $display("FAIL load_q: got %h want a5", q); end
    tests_run++; if (qb !== 8'h5A) begin tests_failed++; $display("FAIL load_qb: got %h want 5a", qb); end
    tests_run++; if (upd !== 1'b1) begin tests_failed++; $display("FAIL load_upd: got %b want 1", upd); end
    tests_run++; if (cmd_cnt !== 16'h0001) begin tests_failed++; $display("FAIL load_cnt: got %h want 0001", cmd_cnt); end
    tick();
    drive_req(0, OP_CLR, 8'h00, 8'h80);
    @(negedge clk);
    tests_run++; if (q !== 8'hAF) begin tests_failed++; $display("FAIL set_q: got %h want af", q); end
    tests_run++; if (upd !== 1'b1) begin tests_failed++; $display("FAIL set_upd: got %b want 1", upd); end
    tick();
    drive_req(0, OP_TOG, 8'h00, 8'hFF);
    @(negedge clk);
    tests_run++; if (q !== 8'h2F) begin tests_failed++; $display("FAIL clr_q: got %h want 2f", q); end
    tests_run++; if (upd !== 1'b1) begin tests_failed++; $display("FAIL clr_upd: got %b want 1", upd); end
    tick();
    drive_req(0, OP_LOAD, 8'h0F, 8'h3C);
    @(negedge clk);
    tests_run++; if (q !== 8'hD0) begin tests_failed++; $display("FAIL tog_q: got %h want d0", q); end
    tests_run++; if (cmd_cnt !== 16'h0004) begin tests_failed++; $display("FAIL tog_cnt: got %h want 0004", cmd_cnt); end
    tick();
    req_valid = '0;
    @(negedge clk);
    tests_run++; if (q !== 8'hCC) begin tests_failed++; $display("FAIL mload_q: got %h want cc", q); end
    tests_run++; if (qb !== 8'h33) begin tests_failed++; $display("FAIL mload_qb: got %h want 33", qb); end
    tick();
    @(negedge clk);
    tests_run++; if (upd !== 1'b0) begin tests_failed++; $display("FAIL ops_idle_upd: got %b want 0", upd); end
    tests_run++; if (q !== 8'hCC) begin tests_failed++; $display("FAIL ops_hold_q: got %h want cc", q); end
  endtask

  task automatic test_round_robin();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_r;
    do_reset();
    for (int i = 0; i < 4; i++) drive_req(i, OP_SET, 8'h00, 8'(1 << i));
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      exp_r = 4'(1 << exp_g[n]);
      tests_run++; if (grant_id !== 3'(exp_g[n])) begin tests_failed++; $display("FAIL rr_gid[%0d]: got %0d want %0d", n, grant_id, exp_g[n]); end
      tests_run++; if (req_ready !== exp_r) begin tests_failed++; $display("FAIL rr_ready[%0d]: got %b want %b", n, req_ready, exp_r); end
      tick();
      if (exp_g[n] != 0) req_valid[exp_g[n]] = 1'b0;
    end
    req_valid = '0;
    @(negedge clk);
    tests_run++; if (q !== 8'h0F) begin tests_failed++; $display("FAIL rr_q: got %h want 0f", q); end
    tests_run++; if (cmd_cnt !== 16'h0005) begin tests_failed++; $display("FAIL rr_cnt: got %h want 0005", cmd_cnt); end
  endtask

  task automatic test_withdraw();
    do_reset();
    drive_req(1, OP_SET, 8'h00, 8'h01);
    drive_req(2, OP_TOG, 8'h00, 8'hFF);
    @(negedge clk);
    tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL wd_ready: got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    @(negedge clk);
    tests_run++; if (q !== 8'h01) begin tests_failed++; $display("FAIL wd_q: got %h want 01", q); end
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL wd_ready_off: got %b want 0000", req_ready); end
    tick();
    @(negedge clk);
    tests_run++; if (q !== 8'h01) begin tests_failed++; $display("FAIL wd_q_hold: got %h want 01", q); end
    tests_run++; if (cmd_cnt !== 16'h0001) begin tests_failed++; $display("FAIL wd_cnt: got %h want 0001", cmd_cnt); end
  endtask

  task automatic test_wrap();
    do_reset();
    drive_req(0, OP_SET, 8'h00, 8'h00);
    repeat (65535) @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    tests_run++; if (cmd_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_pre: got %h want ffff", cmd_cnt); end
    tests_run++; if (q !== 8'h00) begin tests_failed++; $display("FAIL wrap_q: got %h want 00", q); end
    tick();
    req_valid[0] = 1'b1;
    tick();
    req_valid = '0;
    @(negedge clk);
    tests_run++; if (cmd_cnt !== 16'h0000) begin tests_failed++; $display("FAIL wrap_cnt: got %h want 0000", cmd_cnt); end
    tests_run++; if (upd !== 1'b1) begin tests_failed++; $display("FAIL wrap_upd: got %b want 1", upd); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    drive_req(0, OP_LOAD, 8'h3C, 8'hFF);
    tick();
    req_valid = '0;
    @(negedge clk);
    tests_run++; if (q !== 8'h3C) begin tests_failed++; $display("FAIL mid_pre_q: got %h want 3c", q); end
    tick();
    rst = 1'b1;
    drive_req(0, OP_TOG, 8'h00, 8'hFF);
    @(negedge clk);
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL mid_ready: got %b want 0000", req_ready); end
    tests_run++; if (grant_id !== 3'd0) begin tests_failed++; $display("FAIL mid_gid: got %0d want 0", grant_id); end
    tick();
    rst = 1'b0;
    clear_reqs();
    drive_req(0, OP_SET, 8'h00, 8'h00);
    drive_req(1, OP_SET, 8'h00, 8'h00);
    @(negedge clk);
    tests_run++; if (q !== 8'h00) begin tests_failed++; $display("FAIL mid_q: got %h want 00", q); end
    tests_run++; if (qb !== 8'hFF) begin tests_failed++; $display("FAIL mid_qb: got %h want ff", qb); end
    tests_run++; if (upd !== 1'b0) begin tests_failed++; $display("FAIL mid_upd: got %b want 0", upd); end
    tests_run++; if (cmd_cnt !== 16'h0000) begin tests_failed++; $display("FAIL mid_cnt: got %h want 0000", cmd_cnt); end
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL mid_ptr: got %b want 0001", req_ready); end
    tick();
    clear_reqs();
  endtask

  initial begin
    test_reset();
    test_load_ops();
    test_round_robin();
    test_withdraw();
    test_wrap();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
